// File: rtl/matrix_mult_nxn.sv
// N x N matrix multiplier: operand banks, one sequential MAC, addressed result read port.
// Define MATRIX_MULT_SIGNED_EN for two's-complement operands and results (default unsigned).
module matrix_mult_nxn #(
   parameter  int N      = 3,
   parameter  int DATA_W = 16,
   localparam int IDX_W  = $clog2(N),
   localparam int ACC_W  = 2*DATA_W + IDX_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               wr_sel,
   input  logic [IDX_W-1:0]   wr_row,
   input  logic [IDX_W-1:0]   wr_col,
   input  logic [DATA_W-1:0]  wr_data,
   input  logic               start,
   input  logic [IDX_W-1:0]   rd_row,
   input  logic [IDX_W-1:0]   rd_col,
   output logic [ACC_W-1:0]   rd_data,
   output logic               busy,
   output logic               done
);

   // state   | meaning
   // IDLE    | waiting for start, operands writable
   // COMPUTE | one MAC product per cycle, N^3 cycles
   // DONE    | result held until start drops
   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

   localparam logic [IDX_W:0]   N_L  = (IDX_W+1)'(N);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N-1);

   state_t state_q, state_d;

   logic [DATA_W-1:0]   a_mem [N][N];
   logic [DATA_W-1:0]   b_mem [N][N];
   logic [ACC_W-1:0]    c_mem [N][N];
   logic [IDX_W-1:0]    i_q, j_q, k_q;
   logic [ACC_W-1:0]    acc_q;
   logic [DATA_W-1:0]   a_el, b_el;
   logic [2*DATA_W-1:0] prod;
   logic [ACC_W-1:0]    prod_ext;
   logic                last_step;
   logic                wr_ok, rd_ok;

   assign a_el = a_mem[i_q][k_q];
   assign b_el = b_mem[k_q][j_q];

`ifdef MATRIX_MULT_SIGNED_EN
   assign prod     = $signed({{DATA_W{a_el[DATA_W-1]}}, a_el}) *
                     $signed({{DATA_W{b_el[DATA_W-1]}}, b_el});
   assign prod_ext = {{IDX_W{prod[2*DATA_W-1]}}, prod};
`else
   assign prod     = {{DATA_W{1'b0}}, a_el} * {{DATA_W{1'b0}}, b_el};
   assign prod_ext = {{IDX_W{1'b0}}, prod};
`endif

   assign last_step = (i_q == LAST) && (j_q == LAST) && (k_q == LAST);
   assign wr_ok     = wr_en && !busy && ({1'b0, wr_row} < N_L) && ({1'b0, wr_col} < N_L);
   assign rd_ok     = ({1'b0, rd_row} < N_L) && ({1'b0, rd_col} < N_L);
   assign busy      = (state_q == COMPUTE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = start ? COMPUTE : IDLE;
         COMPUTE: state_d = last_step ? DONE : COMPUTE;
         DONE:    state_d = start ? DONE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand banks deliberately have no reset so a reset mid-run keeps them loaded.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         if (wr_sel) b_mem[wr_row][wr_col] <= wr_data;
         else        a_mem[wr_row][wr_col] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         rd_data <= '0;
         done    <= 1'b0;
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               c_mem[r][c] <= '0;
      end else begin
         done    <= (state_q == DONE);
         rd_data <= rd_ok ? c_mem[rd_row][rd_col] : '0;
         if (state_q == IDLE && start) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
         end else if (state_q == COMPUTE) begin
            if (k_q == LAST) begin
               c_mem[i_q][j_q] <= acc_q + prod_ext;
               acc_q <= '0;
               k_q   <= '0;
               if (j_q == LAST) begin
                  j_q <= '0;
                  i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
               end else begin
                  j_q <= j_q + 1'b1;
               end
            end else begin
               acc_q <= acc_q + prod_ext;
               k_q   <= k_q + 1'b1;
            end
         end
      end
   end

endmodule
